// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-register status in, forwarding/stall/flush controls out.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic [4:0]  IDRs, IDRt;
    logic        IDUsesRs, IDUsesRt, IDIsStore, IDBranch, IDJumpR, NPCSrc;
    logic [4:0]  IDEXRs, IDEXRt, IDEXRd;
    logic        IDEXRegWrite, IDEXMemRead, IDEXALUSrc0;
    logic [1:0]  IDEXALUSrc;
    logic [4:0]  EXMEMRd, EXMEMRt;
    logic        EXMEMRegWrite, EXMEMMemRead, EXMEMMemWrite, EXMEMLink;
    logic [4:0]  MEMWBRd;
    logic        MEMWBRegWrite;
    logic [2:0]  EXForwardA, EXForwardB, EXForwardC, MEMForward;
    logic [2:0]  IDForwardJumpR, IDForwardBranchA, IDForwardBranchB;
    logic        PCWrite, IFIDWrite, IDEXFlush, IFIDFlush;
    logic [31:0] StallCnt, FlushCnt;

    modport master (
        output IDRs, IDRt, IDUsesRs, IDUsesRt, IDIsStore, IDBranch, IDJumpR, NPCSrc,
        output IDEXRs, IDEXRt, IDEXRd, IDEXRegWrite, IDEXMemRead, IDEXALUSrc0, IDEXALUSrc,
        output EXMEMRd, EXMEMRt, EXMEMRegWrite, EXMEMMemRead, EXMEMMemWrite, EXMEMLink,
        output MEMWBRd, MEMWBRegWrite,
        input  EXForwardA, EXForwardB, EXForwardC, MEMForward,
        input  IDForwardJumpR, IDForwardBranchA, IDForwardBranchB,
        input  PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, StallCnt, FlushCnt
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRs, IDUsesRt, IDIsStore, IDBranch, IDJumpR, NPCSrc,
        input  IDEXRs, IDEXRt, IDEXRd, IDEXRegWrite, IDEXMemRead, IDEXALUSrc0, IDEXALUSrc,
        input  EXMEMRd, EXMEMRt, EXMEMRegWrite, EXMEMMemRead, EXMEMMemWrite, EXMEMLink,
        input  MEMWBRd, MEMWBRegWrite,
        output EXForwardA, EXForwardB, EXForwardC, MEMForward,
        output IDForwardJumpR, IDForwardBranchA, IDForwardBranchB,
        output PCWrite, IFIDWrite, IDEXFlush, IFIDFlush, StallCnt, FlushCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Forwarding selects, load/branch hazard stalls and IF/ID flush.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  wire          clk,
    input  wire          rstn,
    hazard_ctrl_if.slave hz
);
    localparam logic [2:0] c_FWD_IDEX    = 3'd0;
    localparam logic [2:0] c_FWD_EXMEM   = 3'd1;
    localparam logic [2:0] c_FWD_MEMWB   = 3'd2;
    localparam logic [2:0] c_FWD_RF      = 3'd3;
    localparam logic [2:0] c_FWD_EXMEM_P4 = 3'd4;
    localparam logic [1:0] c_ALUSRC_REG  = 2'd0;

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_STALL = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  r_rem;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    function automatic logic f_hit(input logic we, input logic [4:0] rd, input logic [4:0] src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

    // Nearest non-load producer wins; a load in EX/MEM has no data yet.
    function automatic logic [2:0] f_ex_sel(input logic exmem_hit, input logic exmem_ld,
                                            input logic memwb_hit);
        if (exmem_hit && !exmem_ld) return c_FWD_EXMEM;
        if (memwb_hit)              return c_FWD_MEMWB;
        return c_FWD_IDEX;
    endfunction

    logic [4:0] w_src_a;
    logic [2:0] w_fwd_a, w_fwd_b, w_fwd_c, w_fwd_mem, w_fwd_jr, w_fwd_bra, w_fwd_brb;
    logic       w_ex_rs, w_ex_rt, w_ex_src_a, w_wb_src_a, w_wb_rt;
    logic       w_idex_rs, w_idex_rt, w_ctl, w_need2, w_need1, w_stall, w_ifid_flush;
    logic [1:0] w_rem_nxt;

    assign w_src_a    = hz.IDEXALUSrc0 ? hz.IDEXRt : hz.IDEXRs;
    assign w_ex_src_a = f_hit(hz.EXMEMRegWrite, hz.EXMEMRd, w_src_a);
    assign w_wb_src_a = f_hit(hz.MEMWBRegWrite, hz.MEMWBRd, w_src_a);
    assign w_wb_rt    = f_hit(hz.MEMWBRegWrite, hz.MEMWBRd, hz.IDEXRt);

    assign w_fwd_a = f_ex_sel(w_ex_src_a, hz.EXMEMMemRead, w_wb_src_a);
    assign w_fwd_c = f_ex_sel(f_hit(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDEXRt),
                              hz.EXMEMMemRead, w_wb_rt);
    assign w_fwd_b = (hz.IDEXALUSrc == c_ALUSRC_REG) ? w_fwd_c : c_FWD_IDEX;

    assign w_fwd_mem = (hz.EXMEMMemWrite && f_hit(hz.MEMWBRegWrite, hz.MEMWBRd, hz.EXMEMRt))
                       ? c_FWD_MEMWB : c_FWD_EXMEM;

    // ID-stage operands: MEM/WB is covered by the write-through register file.
    assign w_ex_rs = f_hit(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDRs);
    assign w_ex_rt = f_hit(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDRt);

    assign w_fwd_bra = (w_ex_rs && !hz.EXMEMMemRead) ? c_FWD_EXMEM : c_FWD_RF;
    assign w_fwd_brb = (w_ex_rt && !hz.EXMEMMemRead) ? c_FWD_EXMEM : c_FWD_RF;
    assign w_fwd_jr  = (w_ex_rs && hz.EXMEMLink) ? c_FWD_EXMEM_P4 :
                       (w_ex_rs && !hz.EXMEMMemRead) ? c_FWD_EXMEM : c_FWD_RF;

    assign w_idex_rs = hz.IDUsesRs && f_hit(hz.IDEXRegWrite, hz.IDEXRd, hz.IDRs);
    assign w_idex_rt = hz.IDUsesRt && f_hit(hz.IDEXRegWrite, hz.IDEXRd, hz.IDRt);
    assign w_ctl     = hz.IDBranch || hz.IDJumpR;

    assign w_need2 = w_ctl && hz.IDEXMemRead && (w_idex_rs || w_idex_rt);
    assign w_need1 = (w_ctl && !hz.IDEXMemRead && (w_idex_rs || w_idex_rt))
                  || (w_ctl && hz.EXMEMMemRead && ((hz.IDUsesRs && w_ex_rs) ||
                                                   (hz.IDUsesRt && w_ex_rt)))
                  || (hz.IDEXMemRead && (w_idex_rs || (w_idex_rt && !hz.IDIsStore)));

    assign w_stall      = (r_state == c_ST_STALL) || w_need2 || w_need1;
    assign w_ifid_flush = !w_stall && hz.NPCSrc;
    assign w_rem_nxt    = r_rem - 2'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_RUN;
            r_rem       <= 2'd0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_need2) begin
                        r_state <= c_ST_STALL;
                        r_rem   <= 2'd1;
                    end
                end
                default: begin
                    r_rem <= w_rem_nxt;
                    if (w_rem_nxt == 2'd0) r_state <= c_ST_RUN;
                end
            endcase
            if (w_stall)      r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_ifid_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    // Every control output holds its idle value while reset is asserted.
    assign hz.EXForwardA       = rstn ? w_fwd_a   : c_FWD_IDEX;
    assign hz.EXForwardB       = rstn ? w_fwd_b   : c_FWD_IDEX;
    assign hz.EXForwardC       = rstn ? w_fwd_c   : c_FWD_IDEX;
    assign hz.MEMForward       = rstn ? w_fwd_mem : c_FWD_EXMEM;
    assign hz.IDForwardJumpR   = rstn ? w_fwd_jr  : c_FWD_RF;
    assign hz.IDForwardBranchA = rstn ? w_fwd_bra : c_FWD_RF;
    assign hz.IDForwardBranchB = rstn ? w_fwd_brb : c_FWD_RF;
    assign hz.PCWrite          = !rstn || !w_stall;
    assign hz.IFIDWrite        = !rstn || !w_stall;
    assign hz.IDEXFlush        = rstn && w_stall;
    assign hz.IFIDFlush        = rstn && w_ifid_flush;
    assign hz.StallCnt         = r_stall_cnt;
    assign hz.FlushCnt         = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed hazard scenarios plus random traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam logic [2:0] F_IDEX  = 3'd0;
    localparam logic [2:0] F_EXMEM = 3'd1;
    localparam logic [2:0] F_MEMWB = 3'd2;
    localparam logic [2:0] F_RF    = 3'd3;
    localparam logic [2:0] F_P4    = 3'd4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();
    hazard_ctrl dut (.clk(clk), .rstn(rstn), .hz(hz));

    int vectors = 0;
    int miscompares = 0;

    int          m_pend = 0;
    int          e_n = 0;
    bit          e_stall, e_flush;
    logic [31:0] m_sc = 0, m_fc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit writes(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return we && (rd != 5'd0) && (rd == r);
    endfunction

    function automatic logic [2:0] m_ex(input logic [4:0] r);
        if (writes(hz.EXMEMRegWrite, hz.EXMEMRd, r) && !hz.EXMEMMemRead) return F_EXMEM;
        if (writes(hz.MEMWBRegWrite, hz.MEMWBRd, r)) return F_MEMWB;
        return F_IDEX;
    endfunction

    function automatic int m_demand();
        bit ctl, idex_hit, exmem_hit, loaduse;
        ctl       = hz.IDBranch || hz.IDJumpR;
        idex_hit  = (hz.IDUsesRs && writes(hz.IDEXRegWrite, hz.IDEXRd, hz.IDRs)) ||
                    (hz.IDUsesRt && writes(hz.IDEXRegWrite, hz.IDEXRd, hz.IDRt));
        exmem_hit = (hz.IDUsesRs && writes(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDRs)) ||
                    (hz.IDUsesRt && writes(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDRt));
        loaduse   = hz.IDEXMemRead &&
                    ((hz.IDUsesRs && writes(hz.IDEXRegWrite, hz.IDEXRd, hz.IDRs)) ||
                     (!hz.IDIsStore && hz.IDUsesRt && writes(hz.IDEXRegWrite, hz.IDEXRd, hz.IDRt)));
        if (ctl && idex_hit && hz.IDEXMemRead) return 2;
        if ((ctl && idex_hit) || (ctl && exmem_hit && hz.EXMEMMemRead) || loaduse) return 1;
        return 0;
    endfunction

    // Let inputs settle, then compare every output with the model.
    task automatic settle();
        logic [2:0] ea, eb, ec, em, ej, eba, ebb;
        logic [4:0] srca;
        #1;
        if (!rstn) begin
            m_pend = 0; m_sc = 0; m_fc = 0; e_n = 0;
            ea = F_IDEX; eb = F_IDEX; ec = F_IDEX; em = F_EXMEM;
            ej = F_RF; eba = F_RF; ebb = F_RF;
            e_stall = 1'b0; e_flush = 1'b0;
        end else begin
            srca = hz.IDEXALUSrc0 ? hz.IDEXRt : hz.IDEXRs;
            ea = m_ex(srca);
            ec = m_ex(hz.IDEXRt);
            eb = (hz.IDEXALUSrc == 2'd0) ? ec : F_IDEX;
            em = (hz.EXMEMMemWrite && writes(hz.MEMWBRegWrite, hz.MEMWBRd, hz.EXMEMRt))
                 ? F_MEMWB : F_EXMEM;
            eba = (writes(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDRs) && !hz.EXMEMMemRead) ? F_EXMEM : F_RF;
            ebb = (writes(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDRt) && !hz.EXMEMMemRead) ? F_EXMEM : F_RF;
            if (writes(hz.EXMEMRegWrite, hz.EXMEMRd, hz.IDRs) && hz.EXMEMLink) ej = F_P4;
            else ej = eba;
            e_n     = (m_pend > 0) ? 0 : m_demand();
            e_stall = (m_pend > 0) || (e_n > 0);
            e_flush = !e_stall && hz.NPCSrc;
        end
        chk("EXForwardA", {29'd0, hz.EXForwardA}, {29'd0, ea});
        chk("EXForwardB", {29'd0, hz.EXForwardB}, {29'd0, eb});
        chk("EXForwardC", {29'd0, hz.EXForwardC}, {29'd0, ec});
        chk("MEMForward", {29'd0, hz.MEMForward}, {29'd0, em});
        chk("IDForwardJumpR", {29'd0, hz.IDForwardJumpR}, {29'd0, ej});
        chk("IDForwardBranchA", {29'd0, hz.IDForwardBranchA}, {29'd0, eba});
        chk("IDForwardBranchB", {29'd0, hz.IDForwardBranchB}, {29'd0, ebb});
        chk("PCWrite", {31'd0, hz.PCWrite}, {31'd0, !e_stall});
        chk("IFIDWrite", {31'd0, hz.IFIDWrite}, {31'd0, !e_stall});
        chk("IDEXFlush", {31'd0, hz.IDEXFlush}, {31'd0, e_stall});
        chk("IFIDFlush", {31'd0, hz.IFIDFlush}, {31'd0, e_flush});
        chk("StallCnt", hz.StallCnt, m_sc);
        chk("FlushCnt", hz.FlushCnt, m_fc);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rstn) begin
            if (m_pend > 0) m_pend = m_pend - 1;
            else if (e_n > 0) m_pend = e_n - 1;
            if (e_stall) m_sc = m_sc + 32'd1;
            if (e_flush) m_fc = m_fc + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        hz.IDRs = 0; hz.IDRt = 0; hz.IDUsesRs = 0; hz.IDUsesRt = 0; hz.IDIsStore = 0;
        hz.IDBranch = 0; hz.IDJumpR = 0; hz.NPCSrc = 0;
        hz.IDEXRs = 0; hz.IDEXRt = 0; hz.IDEXRd = 0; hz.IDEXRegWrite = 0;
        hz.IDEXMemRead = 0; hz.IDEXALUSrc0 = 0; hz.IDEXALUSrc = 0;
        hz.EXMEMRd = 0; hz.EXMEMRt = 0; hz.EXMEMRegWrite = 0; hz.EXMEMMemRead = 0;
        hz.EXMEMMemWrite = 0; hz.EXMEMLink = 0; hz.MEMWBRd = 0; hz.MEMWBRegWrite = 0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        settle();
        advance();
        rstn = 1'b1;
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    task automatic randomize_inputs();
        hz.IDRs = rreg(); hz.IDRt = rreg();
        hz.IDUsesRs = 1'($urandom); hz.IDUsesRt = 1'($urandom); hz.IDIsStore = 1'($urandom);
        hz.IDBranch = ($urandom_range(0, 3) == 0); hz.IDJumpR = ($urandom_range(0, 5) == 0);
        hz.NPCSrc = 1'($urandom);
        hz.IDEXRs = rreg(); hz.IDEXRt = rreg(); hz.IDEXRd = rreg();
        hz.IDEXRegWrite = 1'($urandom); hz.IDEXMemRead = 1'($urandom);
        hz.IDEXALUSrc0 = 1'($urandom); hz.IDEXALUSrc = 2'($urandom);
        hz.EXMEMRd = rreg(); hz.EXMEMRt = rreg(); hz.EXMEMRegWrite = 1'($urandom);
        hz.EXMEMMemRead = 1'($urandom); hz.EXMEMMemWrite = 1'($urandom);
        hz.EXMEMLink = ($urandom_range(0, 3) == 0);
        hz.MEMWBRd = rreg(); hz.MEMWBRegWrite = 1'($urandom);
        rstn = ($urandom_range(0, 60) != 0);
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // forwarding priority: EX/MEM over MEM/WB over register value
        hz.IDEXRs = 5'd3; hz.EXMEMRegWrite = 1; hz.EXMEMRd = 5'd3;
        hz.MEMWBRegWrite = 1; hz.MEMWBRd = 5'd3;
        settle(); chk("prio_exmem", {29'd0, hz.EXForwardA}, {29'd0, F_EXMEM});
        advance();
        hz.EXMEMRegWrite = 0;
        settle(); chk("prio_memwb", {29'd0, hz.EXForwardA}, {29'd0, F_MEMWB});
        advance();
        hz.IDEXRs = 0; hz.EXMEMRegWrite = 1; hz.EXMEMRd = 0; hz.MEMWBRd = 0;
        settle(); chk("prio_r0", {29'd0, hz.EXForwardA}, {29'd0, F_IDEX});
        advance();

        // load-use: one bubble
        do_reset();
        hz.IDEXRegWrite = 1; hz.IDEXMemRead = 1; hz.IDEXRd = 5'd5;
        hz.IDRs = 5'd5; hz.IDUsesRs = 1;
        settle();
        chk("lu_pcwrite", {31'd0, hz.PCWrite}, 32'd0);
        chk("lu_idexflush", {31'd0, hz.IDEXFlush}, 32'd1);
        advance();
        hz.IDEXRegWrite = 0; hz.IDEXMemRead = 0; hz.IDEXRd = 0;
        settle();
        chk("lu_release", {31'd0, hz.PCWrite}, 32'd1);
        chk("lu_stallcnt", hz.StallCnt, 32'd1);
        advance();

        // store with rt-only dependence proceeds, later forwarded in MEM
        idle();
        hz.IDEXRegWrite = 1; hz.IDEXMemRead = 1; hz.IDEXRd = 5'd5;
        hz.IDIsStore = 1; hz.IDRs = 5'd2; hz.IDUsesRs = 1; hz.IDRt = 5'd5; hz.IDUsesRt = 1;
        settle(); chk("sw_nostall", {31'd0, hz.PCWrite}, 32'd1);
        advance();
        idle();
        hz.EXMEMMemWrite = 1; hz.EXMEMRt = 5'd5; hz.MEMWBRegWrite = 1; hz.MEMWBRd = 5'd5;
        settle(); chk("sw_memfwd", {29'd0, hz.MEMForward}, {29'd0, F_MEMWB});
        advance();

        // branch after load: two bubbles, flush held off until resolved
        do_reset();
        hz.IDEXRegWrite = 1; hz.IDEXMemRead = 1; hz.IDEXRd = 5'd4;
        hz.IDBranch = 1; hz.IDRs = 5'd4; hz.IDUsesRs = 1; hz.NPCSrc = 1;
        settle();
        chk("bl_stall1", {31'd0, hz.PCWrite}, 32'd0);
        chk("bl_noflush1", {31'd0, hz.IFIDFlush}, 32'd0);
        advance();
        hz.IDEXRegWrite = 0; hz.IDEXMemRead = 0; hz.IDEXRd = 0;
        hz.EXMEMRegWrite = 1; hz.EXMEMMemRead = 1; hz.EXMEMRd = 5'd4;
        settle();
        chk("bl_stall2", {31'd0, hz.PCWrite}, 32'd0);
        chk("bl_noflush2", {31'd0, hz.IFIDFlush}, 32'd0);
        advance();
        hz.EXMEMRegWrite = 0; hz.EXMEMMemRead = 0; hz.EXMEMRd = 0;
        hz.MEMWBRegWrite = 1; hz.MEMWBRd = 5'd4;
        settle();
        chk("bl_run", {31'd0, hz.PCWrite}, 32'd1);
        chk("bl_stallcnt", hz.StallCnt, 32'd2);
        chk("bl_flush", {31'd0, hz.IFIDFlush}, 32'd1);
        advance();

        // jr after jal
        do_reset();
        hz.EXMEMRegWrite = 1; hz.EXMEMRd = 5'd31; hz.EXMEMLink = 1;
        hz.IDJumpR = 1; hz.IDRs = 5'd31; hz.IDUsesRs = 1; hz.NPCSrc = 1;
        settle();
        chk("jr_p4", {29'd0, hz.IDForwardJumpR}, {29'd0, F_P4});
        chk("jr_nostall", {31'd0, hz.PCWrite}, 32'd1);
        chk("jr_flush", {31'd0, hz.IFIDFlush}, 32'd1);
        advance();
        idle();
        settle(); chk("jr_flushcnt", hz.FlushCnt, 32'd1);
        advance();

        // reset while the two-cycle stall is in progress
        do_reset();
        hz.IDEXRegWrite = 1; hz.IDEXMemRead = 1; hz.IDEXRd = 5'd4;
        hz.IDBranch = 1; hz.IDRs = 5'd4; hz.IDUsesRs = 1;
        settle();
        advance();
        idle();
        rstn = 1'b0;
        settle();
        chk("rst_pcwrite", {31'd0, hz.PCWrite}, 32'd1);
        chk("rst_stallcnt", hz.StallCnt, 32'd0);
        advance();
        rstn = 1'b1;
        settle();
        chk("rst_run", {31'd0, hz.PCWrite}, 32'd1);
        advance();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
